cu_fsm: RTL and testbench

- Sequencing control unit for the multicycle RV32I core.
- Drives per-instruction timing strobes: fetch, execute, load writeback and interrupt entry.
- Works with the combinational decoder. The decoder chooses mux selects and ALU function; this block decides when the PC, register file, memory and CSRs are written.
- Sits between the instruction/data memory handshake and the datapath enables.

---
 rtl/otter_pkg.sv | 38 +++
 rtl/cu_fsm.sv | 142 ++++++++++++++
 tb/tb_cu_fsm.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared definitions for the multicycle RV32I core: opcode map, control-unit
// states and the FUNC3 values the control unit needs to tell SYSTEM ops apart.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2,
        INTR  = 2'd3
    } cu_state_t;

    localparam logic [2:0] CSRRW = 3'b001;
    localparam logic [2:0] MRET  = 3'b000;

    // Opcodes whose result lands in rd in the same cycle they execute.
    function automatic logic writes_rd_in_exec(input logic [6:0] opcode);
        logic hit;
        case (opcode)
            LUI, AUIPC, JAL, JALR, OP_IMM, OP: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/cu_fsm.sv
// Sequencing control unit: decides in which cycle the PC, register file,
// memory ports and CSRs are strobed. Outputs are Mealy (state plus inputs).
module cu_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] CU_OPCODE,
    input  logic [2:0] FUNC3,
    input  logic       INTR,
    input  logic       CSR_MIE,
    input  logic       MEM_RDY,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       PC_RST
);
    import otter_pkg::*;

    // The state INTR is named with its package scope because the port INTR
    // (the interrupt request level) shadows the imported enum member.
    cu_state_t state_r;
    cu_state_t next_state_s;
    cu_state_t done_state_s;
    logic      rdy_s;
    logic      irq_s;

    assign rdy_s = MEM_WAIT_EN ? MEM_RDY : 1'b1;
    assign irq_s = INTR & CSR_MIE;

    // Where an instruction goes once it completes: interrupt entry or next fetch.
    always_comb begin
        if (irq_s) begin
            done_state_s = otter_pkg::INTR;
        end else begin
            done_state_s = FETCH;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        next_state_s = state_r;
        PC_WRITE     = 1'b0;
        REG_WRITE    = 1'b0;
        MEM_RDEN1    = 1'b0;
        MEM_RDEN2    = 1'b0;
        MEM_WE2      = 1'b0;
        CSR_WE       = 1'b0;
        INT_TAKEN    = 1'b0;
        PC_RST       = 1'b0;

        if (RST) begin
            PC_RST       = 1'b1;
            next_state_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    MEM_RDEN1 = 1'b1;
                    if (rdy_s) begin
                        next_state_s = EXEC;
                    end else begin
                        next_state_s = FETCH;
                    end
                end

                EXEC: begin
                    case (CU_OPCODE)
                        LOAD: begin
                            MEM_RDEN2    = 1'b1;
                            next_state_s = WB;
                        end
                        STORE: begin
                            MEM_WE2 = 1'b1;
                            if (rdy_s) begin
                                PC_WRITE     = 1'b1;
                                next_state_s = done_state_s;
                            end else begin
                                next_state_s = EXEC;
                            end
                        end
                        BRANCH: begin
                            PC_WRITE     = 1'b1;
                            next_state_s = done_state_s;
                        end
                        SYSTEM: begin
                            PC_WRITE     = 1'b1;
                            next_state_s = done_state_s;
                            if (FUNC3 == CSRRW) begin
                                CSR_WE    = 1'b1;
                                REG_WRITE = 1'b1;
                            end else begin
                                CSR_WE    = 1'b0;
                                REG_WRITE = 1'b0;
                            end
                        end
                        default: begin
                            // Unknown opcodes retire as NOPs.
                            PC_WRITE     = 1'b1;
                            REG_WRITE    = writes_rd_in_exec(CU_OPCODE);
                            next_state_s = done_state_s;
                        end
                    endcase
                end

                WB: begin
                    MEM_RDEN2 = 1'b1;
                    if (rdy_s) begin
                        REG_WRITE    = 1'b1;
                        PC_WRITE     = 1'b1;
                        next_state_s = done_state_s;
                    end else begin
                        next_state_s = WB;
                    end
                end

                otter_pkg::INTR: begin
                    INT_TAKEN    = 1'b1;
                    PC_WRITE     = 1'b1;
                    next_state_s = FETCH;
                end

                default: begin
                    next_state_s = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: literal per-cycle expectations plus an
// instruction-level model compared against the strobes on every cycle.
module tb_cu_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] CU_OPCODE;
    logic [2:0] FUNC3;
    logic       INTR;
    logic       CSR_MIE;
    logic       MEM_RDY;
    logic       PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2;
    logic       MEM_WE2, CSR_WE, INT_TAKEN, PC_RST;

    always #5 CLK = ~CLK;

    cu_fsm dut (
        .CLK(CLK), .RST(RST), .CU_OPCODE(CU_OPCODE), .FUNC3(FUNC3),
        .INTR(INTR), .CSR_MIE(CSR_MIE), .MEM_RDY(MEM_RDY),
        .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE), .MEM_RDEN1(MEM_RDEN1),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .CSR_WE(CSR_WE),
        .INT_TAKEN(INT_TAKEN), .PC_RST(PC_RST)
    );

    // Bit order: PC_RST PC_WRITE REG_WRITE RDEN1 RDEN2 WE2 CSR_WE INT_TAKEN
    logic [7:0] obs;
    assign obs = {PC_RST, PC_WRITE, REG_WRITE, MEM_RDEN1,
                  MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN};

    localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
    localparam logic [6:0] O_JAL = 7'b1101111, O_JALR = 7'b1100111;
    localparam logic [6:0] O_BR  = 7'b1100011, O_LD   = 7'b0000011;
    localparam logic [6:0] O_ST  = 7'b0100011, O_OPI  = 7'b0010011;
    localparam logic [6:0] O_OP  = 7'b0110011, O_SYS  = 7'b1110011;
    localparam logic [6:0] RD_OPS [6] = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_OPI, O_OP};

    int total  = 0;
    int passed = 0;
    bit run    = 1'b0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %b, expected %b", name, got, want);
    endtask

    function automatic bit writes_rd(input logic [6:0] opc, input logic [2:0] f3);
        bit w = (opc == O_SYS) && (f3 == 3'b001);
        foreach (RD_OPS[i]) if (RD_OPS[i] == opc) w = 1'b1;
        return w;
    endfunction

    // Model: where the current instruction is in its life.
    // 0 waiting for fetch, 1 executing, 2 waiting for load data, 3 interrupt entry.
    int         m_where = 0;
    int         m_next;
    bit         m_retire;
    logic [7:0] m_want;

    always @(negedge CLK) begin
        if (run) begin
            m_want   = 8'h00;
            m_next   = m_where;
            m_retire = 1'b0;
            if (RST) begin
                m_want = 8'h80;
                m_next = 0;
            end else if (m_where == 0) begin
                m_want[4] = 1'b1;
                m_next    = MEM_RDY ? 1 : 0;
            end else if (m_where == 1) begin
                if (CU_OPCODE == O_LD) begin
                    m_want[3] = 1'b1;
                    m_next    = 2;
                end else if (CU_OPCODE == O_ST) begin
                    m_want[2] = 1'b1;
                    m_want[6] = MEM_RDY;
                    m_retire  = MEM_RDY;
                end else begin
                    m_want[6] = 1'b1;
                    m_want[5] = writes_rd(CU_OPCODE, FUNC3);
                    m_want[1] = (CU_OPCODE == O_SYS) && (FUNC3 == 3'b001);
                    m_retire  = 1'b1;
                end
            end else if (m_where == 2) begin
                m_want[3] = 1'b1;
                m_want[6] = MEM_RDY;
                m_want[5] = MEM_RDY;
                m_retire  = MEM_RDY;
            end else begin
                m_want = 8'h41;
                m_next = 0;
            end
            if (m_retire) m_next = (INTR && CSR_MIE) ? 3 : 0;
            check("model", obs, m_want);
            total++;
            if ($countones({MEM_RDEN1, MEM_RDEN2, MEM_WE2}) <= 1) passed++;
            else $display("FAIL mem_onehot: got %b, expected at most one set",
                          {MEM_RDEN1, MEM_RDEN2, MEM_WE2});
            m_where = m_next;
        end
    end

    // One clock cycle: drive inputs after the edge, check strobes mid-cycle.
    task automatic cyc(input bit rst, input logic [6:0] opc, input logic [2:0] f3,
                       input bit intr, input bit mie, input bit rdy,
                       input logic [7:0] want, input string name);
        @(posedge CLK);
        #1;
        RST = rst; CU_OPCODE = opc; FUNC3 = f3;
        INTR = intr; CSR_MIE = mie; MEM_RDY = rdy;
        @(negedge CLK);
        check(name, obs, want);
    endtask

    initial begin
        RST = 1'b1; CU_OPCODE = O_OP; FUNC3 = 3'b000;
        INTR = 1'b0; CSR_MIE = 1'b0; MEM_RDY = 1'b1;
        run = 1'b1;
        //   rst opcode  f3      irq mie rdy want    name
        cyc(1, O_OP,  3'b000, 0, 0, 1, 8'h80, "reset_0");
        cyc(1, O_OP,  3'b000, 0, 0, 1, 8'h80, "reset_1");
        cyc(0, O_OP,  3'b000, 0, 0, 1, 8'h10, "op_fetch");
        cyc(0, O_OP,  3'b000, 0, 0, 1, 8'h60, "op_exec");
        cyc(0, O_LD,  3'b010, 0, 0, 1, 8'h10, "op_refetch");
        cyc(0, O_LD,  3'b010, 0, 0, 0, 8'h08, "ld_exec");
        cyc(0, O_LD,  3'b010, 1, 1, 0, 8'h08, "ld_wait_0");
        cyc(0, O_LD,  3'b010, 1, 1, 0, 8'h08, "ld_wait_1");
        cyc(0, O_LD,  3'b010, 1, 1, 0, 8'h08, "ld_wait_2");
        cyc(0, O_LD,  3'b010, 1, 1, 1, 8'h68, "ld_done");
        cyc(0, O_ST,  3'b010, 0, 0, 0, 8'h41, "ld_irq_entry");
        cyc(0, O_ST,  3'b010, 0, 0, 0, 8'h10, "fetch_stall");
        cyc(0, O_ST,  3'b010, 0, 0, 1, 8'h10, "st_fetch");
        cyc(0, O_ST,  3'b010, 0, 0, 0, 8'h04, "st_wait_0");
        cyc(0, O_ST,  3'b010, 0, 0, 0, 8'h04, "st_wait_1");
        cyc(0, O_ST,  3'b010, 0, 0, 1, 8'h44, "st_done");
        cyc(0, O_BR,  3'b000, 1, 1, 1, 8'h10, "br_fetch_irq");
        cyc(0, O_BR,  3'b000, 1, 1, 1, 8'h40, "br_exec_irq");
        cyc(0, O_BR,  3'b000, 1, 0, 1, 8'h41, "irq_entry");
        cyc(0, O_BR,  3'b000, 1, 0, 1, 8'h10, "irq_refetch");
        cyc(0, O_BR,  3'b000, 1, 0, 1, 8'h40, "br_exec_masked");
        cyc(0, O_SYS, 3'b001, 0, 0, 1, 8'h10, "masked_to_fetch");
        cyc(0, O_SYS, 3'b001, 0, 0, 1, 8'h62, "csrrw_exec");
        cyc(0, 7'd0,  3'b000, 0, 0, 1, 8'h10, "nop_fetch");
        cyc(0, 7'd0,  3'b000, 0, 0, 1, 8'h40, "illegal_exec");
        cyc(0, O_SYS, 3'b000, 0, 0, 1, 8'h10, "mret_fetch");
        cyc(0, O_SYS, 3'b000, 0, 0, 1, 8'h40, "mret_exec");
        cyc(0, O_JAL, 3'b000, 0, 0, 1, 8'h10, "jal_fetch");
        cyc(0, O_JAL, 3'b000, 0, 0, 1, 8'h60, "jal_exec");
        cyc(0, O_LD,  3'b000, 0, 0, 1, 8'h10, "ld2_fetch");
        cyc(0, O_LD,  3'b000, 0, 0, 1, 8'h08, "ld2_exec");
        cyc(1, O_LD,  3'b000, 0, 0, 1, 8'h80, "rst_in_wb");
        cyc(0, O_OP,  3'b000, 0, 0, 1, 8'h10, "post_rst_fetch");
        cyc(0, O_OP,  3'b000, 0, 0, 1, 8'h60, "post_rst_exec");
        @(posedge CLK);
        #1;
        run = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
